// File: rtl/i2c_codec_target.sv
// I2C write-only target standing in for the audio codec control port.
// Decodes 3-byte writes, ACKs them, strobes each write and mirrors regs 0..15.
module i2c_codec_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       o_REG_WE,
    output logic [6:0] o_REG_ADDR,
    output logic [8:0] o_REG_DATA,
    input  logic [3:0] i_RD_ADDR,
    output logic [8:0] o_RD_DATA,
    output logic       o_ACTIVE,
    output logic       o_BUSY
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAckA, StB1, StAck1, StB2, StAck2, StExtra, StAckX, StIgnore
    } stateT;

    stateT                  stateQ, stateD;
    logic [SYNC_STAGES-1:0] sclSyncQ, sdaSyncQ;
    logic                   sclDlyQ, sdaDlyQ;
    logic [SYNC_STAGES:0]   oeHistQ;
    logic [3:0]             bitCntQ, bitCntD;
    logic [7:0]             shiftQ, shiftD;
    logic [7:0]             b1Q, b1D;
    logic                   oeQ, oeD;
    logic                   weQ;
    logic [6:0]             regAddrQ;
    logic [8:0]             regDataQ;
    logic [8:0]             shadowQ [16];
    logic                   commit;

    logic sclS, sdaS, sdaMask, sclRise, sclFall, startEv, stopEv, addrMatch;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclSyncQ <= '1;
            sdaSyncQ <= '1;
            sclDlyQ  <= 1'b1;
            sdaDlyQ  <= 1'b1;
            oeHistQ  <= '0;
        end else begin
            sclSyncQ <= {sclSyncQ[SYNC_STAGES-2:0], I2C_SCLK};
            sdaSyncQ <= {sdaSyncQ[SYNC_STAGES-2:0], I2C_SDAT};
            sclDlyQ  <= sclS;
            sdaDlyQ  <= sdaS;
            oeHistQ  <= {oeHistQ[SYNC_STAGES-1:0], oeQ};
        end
    end

    assign sclS    = sclSyncQ[SYNC_STAGES-1];
    assign sdaS    = sdaSyncQ[SYNC_STAGES-1];
    // Our own ACK edges reach the synchronizer late, so keep masking until they drain.
    assign sdaMask = oeQ | (|oeHistQ);
    assign sclRise = sclS & ~sclDlyQ;
    assign sclFall = ~sclS & sclDlyQ;
    assign startEv = sclS & sclDlyQ & sdaDlyQ & ~sdaS & ~sdaMask;
    assign stopEv  = sclS & sclDlyQ & ~sdaDlyQ & sdaS & ~sdaMask;
    assign addrMatch = (shiftQ == {DEV_ADDR, 1'b0});

    always_comb begin
        stateD  = stateQ;
        bitCntD = bitCntQ;
        shiftD  = shiftQ;
        b1D     = b1Q;
        oeD     = oeQ;
        commit  = 1'b0;
        if (startEv) begin
            stateD  = StAddr;
            bitCntD = '0;
            oeD     = 1'b0;
        end else if (stopEv) begin
            stateD = StIdle;
            oeD    = 1'b0;
        end else begin
            unique case (stateQ)
                StAddr, StB1, StB2, StExtra: begin
                    if (sclRise && bitCntQ != 4'd8) begin
                        shiftD  = {shiftQ[6:0], sdaS};
                        bitCntD = bitCntQ + 4'd1;
                    end else if (sclFall && bitCntQ == 4'd8) begin
                        bitCntD = '0;
                        if (stateQ == StAddr) begin
                            stateD = StAckA;
                            oeD    = addrMatch;
                        end else if (stateQ == StB1) begin
                            stateD = StAck1;
                            oeD    = 1'b1;
                            b1D    = shiftQ;
                        end else if (stateQ == StB2) begin
                            stateD = StAck2;
                            oeD    = 1'b1;
                        end else begin
                            stateD = StAckX;
                        end
                    end
                end
                StAckA: begin
                    if (sclFall) begin
                        oeD    = 1'b0;
                        stateD = oeQ ? StB1 : StIgnore;
                    end
                end
                StAck1: begin
                    if (sclFall) begin
                        oeD    = 1'b0;
                        stateD = StB2;
                    end
                end
                StAck2: begin
                    if (sclFall) begin
                        oeD    = 1'b0;
                        stateD = StExtra;
                        commit = 1'b1;
                    end
                end
                StAckX: begin
                    if (sclFall) begin
                        stateD = StExtra;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateQ  <= StIdle;
            bitCntQ <= '0;
            shiftQ  <= '0;
            b1Q     <= '0;
            oeQ     <= 1'b0;
        end else begin
            stateQ  <= stateD;
            bitCntQ <= bitCntD;
            shiftQ  <= shiftD;
            b1Q     <= b1D;
            oeQ     <= oeD;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            weQ      <= 1'b0;
            regAddrQ <= '0;
            regDataQ <= '0;
            for (int i = 0; i < 16; i++) begin
                shadowQ[i] <= '0;
            end
        end else begin
            weQ <= commit;
            if (commit) begin
                regAddrQ <= b1Q[7:1];
                regDataQ <= {b1Q[0], shiftQ};
                // Register 0x0F is the codec reset register: it wipes the whole file.
                if (b1Q[7:1] == 7'h0F) begin
                    for (int i = 0; i < 16; i++) begin
                        shadowQ[i] <= '0;
                    end
                end else if (b1Q[7:5] == 3'b000) begin
                    shadowQ[b1Q[4:1]] <= {b1Q[0], shiftQ};
                end
            end
        end
    end

    assign I2C_SDAT   = oeQ ? 1'b0 : 1'bz;
    assign o_REG_WE   = weQ;
    assign o_REG_ADDR = regAddrQ;
    assign o_REG_DATA = regDataQ;
    assign o_RD_DATA  = shadowQ[i_RD_ADDR];
    assign o_ACTIVE   = shadowQ[9][0];
    assign o_BUSY     = startEv | ((stateQ != StIdle) & ~stopEv);

endmodule

// File: tb/tb_i2c_codec_target.sv
// Randomized bench for i2c_codec_target: drives I2C writes as bus master and
// compares ACKs, strobes and the shadow file against a transaction-level model.
module tb_i2c_codec_target;

    localparam int Q = 6;  // iCLK cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       scl = 1'b1;
    logic       tbLow = 1'b0;
    wire        sda;
    logic       regWe;
    logic [6:0] regAddr;
    logic [8:0] regData;
    logic [3:0] rdAddr = '0;
    logic [8:0] rdData;
    logic       active;
    logic       busy;

    int nChecks = 0;
    int nErrors = 0;

    pullup (sda);
    assign sda = tbLow ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_codec_target #(
        .DEV_ADDR   (7'h1A),
        .SYNC_STAGES(2)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rstN),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda),
        .o_REG_WE  (regWe),
        .o_REG_ADDR(regAddr),
        .o_REG_DATA(regData),
        .i_RD_ADDR (rdAddr),
        .o_RD_DATA (rdData),
        .o_ACTIVE  (active),
        .o_BUSY    (busy)
    );

    // Strobe monitor: every cycle with the strobe high is one recorded write.
    logic [15:0] strobeQ[$];
    logic        prevWe = 1'b0;
    int          weLong = 0;
    always @(posedge clk) begin
        if (rstN && regWe) begin
            strobeQ.push_back({regAddr, regData});
            if (prevWe) weLong <= weLong + 1;
        end
        prevWe <= regWe;
    end

    // Reference model state
    logic [8:0] mShadow[16];
    logic [6:0] mRegAddr;
    logic [8:0] mRegData;
    logic [7:0] txBytes[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2cStart();
        tbLow = 1'b0; quarter();
        scl = 1'b1;   quarter();
        tbLow = 1'b1; quarter();
        scl = 1'b0;   quarter();
    endtask

    task automatic i2cStop();
        tbLow = 1'b1; quarter();
        scl = 1'b1;   quarter();
        tbLow = 1'b0; quarter();
    endtask

    task automatic sendBits8(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            tbLow = ~b[i]; quarter();
            scl = 1'b1;    quarter(); quarter();
            scl = 1'b0;    quarter();
        end
        tbLow = 1'b0;
    endtask

    task automatic ackClock(output bit acked);
        quarter();
        scl = 1'b1; quarter();
        acked = (sda === 1'b0);
        quarter();
        scl = 1'b0; quarter();
    endtask

    task automatic sendByte(input logic [7:0] b, output bit acked);
        sendBits8(b);
        ackClock(acked);
    endtask

    task automatic checkOutputs();
        @(negedge clk);
        checkEq("reg_addr", regAddr, mRegAddr);
        checkEq("reg_data", regData, mRegData);
        checkEq("active", active, mShadow[9][0]);
        for (int i = 0; i < 16; i++) begin
            rdAddr = 4'(i);
            #1;
            checkEq($sformatf("shadow[%0d]", i), rdData, mShadow[i]);
        end
    endtask

    task automatic runTxn(input bit endStop);
        bit         acked;
        bit         accept;
        int         expN;
        logic [6:0] ra;
        logic [8:0] rd;
        i2cStart();
        checkEq("busy_after_start", busy, 1);
        accept = (txBytes[0] == 8'h34);
        foreach (txBytes[k]) begin
            sendByte(txBytes[k], acked);
            checkEq($sformatf("ack_byte%0d_%02h", k, txBytes[k]), acked, accept && k < 3);
        end
        if (endStop) begin
            i2cStop();
            checkEq("busy_after_stop", busy, 0);
        end
        repeat (4) @(negedge clk);
        expN = 0;
        ra = '0;
        rd = '0;
        if (accept && txBytes.size() >= 3) begin
            expN = 1;
            ra = txBytes[1][7:1];
            rd = {txBytes[1][0], txBytes[2]};
            mRegAddr = ra;
            mRegData = rd;
            if (ra == 7'h0F) begin
                foreach (mShadow[i]) mShadow[i] = '0;
            end else if (ra < 16) begin
                mShadow[ra[3:0]] = rd;
            end
        end
        checkEq("strobe_count", strobeQ.size(), expN);
        if (expN == 1 && strobeQ.size() == 1) begin
            checkEq("strobe_addr", strobeQ[0][15:9], ra);
            checkEq("strobe_data", strobeQ[0][8:0], rd);
        end
        strobeQ.delete();
        checkOutputs();
    endtask

    task automatic txn(input int n, input logic [31:0] w, input bit endStop);
        txBytes.delete();
        for (int k = n - 1; k >= 0; k--) txBytes.push_back(w[8*k +: 8]);
        runTxn(endStop);
    endtask

    initial begin
        int         n;
        int         sel;
        logic [7:0] b;
        foreach (mShadow[i]) mShadow[i] = '0;
        mRegAddr = '0;
        mRegData = '0;

        repeat (3) @(negedge clk);
        checkEq("rst_we", regWe, 0);
        checkEq("rst_busy", busy, 0);
        checkEq("rst_sda_released", sda, 1);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutputs();

        txn(3, 32'h341E00, 1'b1);
        txn(3, 32'h340812, 1'b1);
        txn(3, 32'h341301, 1'b1);
        txn(3, 32'h360812, 1'b1);
        txn(3, 32'h350812, 1'b1);
        txn(2, 32'h3408, 1'b1);
        txn(2, 32'h3408, 1'b0);
        txn(3, 32'h340C00, 1'b1);
        txn(4, 32'h340A0655, 1'b1);

        // Reset while the target holds the ACK for byte 1
        txn(1, 32'h34, 1'b0);
        sendBits8(8'h08);
        quarter();
        checkEq("ack1_driven", sda, 0);
        rstN = 1'b0;
        #1;
        checkEq("rst_mid_sda", sda, 1);
        checkEq("rst_mid_busy", busy, 0);
        checkEq("rst_mid_we", regWe, 0);
        @(negedge clk);
        rstN = 1'b1;
        foreach (mShadow[i]) mShadow[i] = '0;
        mRegAddr = '0;
        mRegData = '0;
        strobeQ.delete();
        i2cStop();
        checkEq("busy_after_rst", busy, 0);
        txn(3, 32'h341301, 1'b1);

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 4);
            sel = $urandom_range(0, 9);
            txBytes.delete();
            b = (sel < 8) ? 8'h34 : ((sel == 8) ? 8'h36 : 8'h35);
            txBytes.push_back(b);
            for (int k = 1; k < n; k++) begin
                if (k == 1) b = {7'($urandom_range(0, 20)), 1'($urandom_range(0, 1))};
                else b = 8'($urandom);
                txBytes.push_back(b);
            end
            runTxn(($urandom_range(0, 3) != 0) || (t == 29));
        end

        checkEq("we_pulse_width", weLong, 0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/i2c_codec_target.md
# i2c_codec_target

I2C write-only target that models the audio codec's control port. It sits on the same two-wire bus as the codec configuration master, either in simulation benches or on-FPGA in place of a missing codec. It decodes 3-byte write transactions `[device addr + W, {reg[6:0], d[8]}, d[7:0]]` and ACKs them. Each completed write is presented as a one-cycle register-write strobe and stored in a 16-entry shadow register file.

## Interface
- DEV_ADDR, 7'h1A — 7-bit target address (bus byte 8'h34 for a write).
- SYNC_STAGES, 2 — synchronizer depth for SCL/SDA; minimum 2.

- iCLK  in  1  — system clock; must be ≥ 16× SCL frequency.
- iRST_N  in  1  — asynchronous, active-low reset.
- I2C_SCLK  in  1  — bus clock; the target never stretches it.
- I2C_SDAT  inout  1  — open-drain data line. Driven only as 0 or Z; never 1.
- o_REG_WE  out  1  — one-cycle strobe on each completed write.
- o_REG_ADDR  out  7  — register address of the last write; held until the next write.
- o_REG_DATA  out  9  — data of the last write; held until the next write.
- i_RD_ADDR  in  4  — shadow register read index.
- o_RD_DATA  out  9  — combinational read of `shadow[i_RD_ADDR]`.
- o_ACTIVE  out  1  — `shadow[9][0]` (codec active bit).
- o_BUSY  out  1  — high from START until return to IDLE.

## Operation
- Synchronize SCL and SDA through SYNC_STAGES flops. Keep one further registered copy of each for edge detection.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- Data bits are sampled on the SCL rising edge, MSB first.
- States:
  - IDLE → ADDR on START.
  - ADDR (8 bits) → ACK_A.
  - ACK_A → B1 if `addr == DEV_ADDR` and R/W = 0; otherwise NACK and go to IGNORE.
  - B1 (8 bits) → ACK_1 → B2 (8 bits) → ACK_2 → EXTRA.
  - EXTRA: any further byte is NACKed; remain in EXTRA.
  - IGNORE: wait for START or STOP.
- A START detected in any state (repeated start) goes to ADDR and clears the bit counter. Any partial transaction is discarded.
- A STOP detected in any state goes to IDLE. A partial transaction produces no strobe and no shadow update.
- ACK drive:
  - On the SCL falling edge after the 8th bit of an accepted byte, pull SDA low.
  - Release SDA on the next SCL falling edge.
  - NACK means SDA stays Z.
- Write commit, at the SCL falling edge that ends ACK_2:
  - `o_REG_ADDR = B1[7:1]`, `o_REG_DATA = {B1[0], B2}`, `o_REG_WE = 1` for one iCLK.
  - If `addr < 16`: `shadow[addr] <= data`.
  - If `addr == 7'h0F` (reset register): all 16 shadow entries clear to 0 instead of storing the data. The strobe still fires.
  - `addr ≥ 16`: ACKed and strobed, not stored.
- Reset: all shadow entries 0. `o_REG_WE` = 0, `o_REG_ADDR` = 0, `o_REG_DATA` = 0, `o_BUSY` = 0, `o_ACTIVE` = 0, SDA released (Z), state IDLE.

## Timing
- Bus-to-detect latency: SYNC_STAGES + 1 iCLK from a pin transition to the START/STOP/edge event.
- SDA is pulled low or released within SYNC_STAGES + 2 iCLK after the SCL falling edge, well inside the SCL low phase.
- `o_REG_WE` asserts exactly one iCLK after the ACK_2 falling-edge event. The shadow update is visible on `o_RD_DATA` in the same cycle as the strobe.
- `o_BUSY` rises in the cycle the START event is detected. It falls in the cycle the STOP event is detected.
- While the target drives ACK, the SDA edge detector is masked, so the target's own ACK is never seen as START/STOP.
- Reset mid-transaction releases SDA immediately (asynchronously). The block then ignores the bus until the next START.

## Test plan
- Write `34 1E 00` → ACK ×3; `o_REG_WE` pulse with addr 0x0F, data 0x000; all shadow entries read 0.
- Write `34 08 12` then `34 13 01` → two strobes; `shadow[4] = 0x012`, `shadow[9] = 0x101`, `o_ACTIVE = 1`.
- Write to `36` (wrong address) and to `35` (read bit set) → SDA stays Z at the 9th clock; no strobe; shadow unchanged.
- `34 08`, then STOP; also `34 08`, then repeated START + `34 0C 00` → first case no strobe; second case exactly one strobe with addr 0x06, data 0x000.
- `34 0A 06 55` → ACK on bytes 1–3, NACK on the 4th; exactly one strobe with addr 0x05, data 0x006.
- iRST_N pulse during ACK_1 (SDA low) → SDA released in the same cycle; `o_BUSY` = 0; the next full write completes normally.
